instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 18 +
 rtl/instr_fetch_if.sv | 10 +
 rtl/instr_fetch_timer.sv | 22 ++
 rtl/instr_fetch.sv | 85 ++++++++
 tb/tb_instr_fetch.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared processor definitions for the fetch path: widths, reset PC and FSM encoding.
package instr_fetch_pkg;
  localparam int PC_W  = 16;
  localparam int TMR_W = 8;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  // PC arithmetic is modulo 2^PC_W; the carry is dropped.
  function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] a, input logic [PC_W-1:0] b);
    return a + b;
  endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus: fetch unit is master, memory is slave.
interface instr_fetch_if;
  logic                           mem_req;
  logic [instr_fetch_pkg::PC_W-1:0] mem_addr;
  logic                           mem_ack;
  logic [instr_fetch_pkg::PC_W-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instr_fetch_timer.sv
// Fetch wait counter: cleared on FETCH entry, counts un-acked FETCH cycles.
module fetch_timer
  import instr_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMR_W-1:0] limit,
  output logic             expired
);
  logic [TMR_W-1:0] cnt;

  // Count stops at the limit so it can never wrap back below it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clear)             cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == limit);
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, redirect, single outstanding memory read, timeout fault.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_fetch_if.master     mem,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [PC_W-1:0]   imm_ext,
  output logic [PC_W-1:0]   ir,
  output logic              ir_valid,
  output logic [PC_W-1:0]   ir_pc,
  output logic [PC_W-1:0]   pc,
  output logic              fault
);
  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT - 1);

  fetch_state_e    state, nxt;
  logic            ready, issue, ack, expired;
  logic [PC_W-1:0] target;

  // IDLE and VALID are the only states that accept controller commands.
  assign ready  = (state == IDLE) || (state == VALID);
  assign issue  = ready && fetch_en;
  assign ack    = (state == FETCH) && mem.mem_ack;
  assign target = pc_add(ir_pc, imm_ext);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next state and state-decoded outputs; mem_req follows state so reset drops it at once.
  always_comb begin
    nxt         = state;
    mem.mem_req = 1'b0;
    ir_valid    = 1'b0;
    fault       = 1'b0;
    case (state)
      IDLE:    if (fetch_en) nxt = FETCH;
      VALID: begin
        ir_valid = 1'b1;
        if (fetch_en) nxt = FETCH;
      end
      FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) nxt = VALID;   // ack on the limit cycle wins
        else if (expired) nxt = FAULT;
      end
      FAULT:   fault = 1'b1;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: PC/redirect in IDLE/VALID, capture on the ack edge, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      mem.mem_addr <= '0;
      ir           <= '0;
      ir_pc        <= '0;
    end else if (ready) begin
      if (redirect) pc <= target;
      if (fetch_en) mem.mem_addr <= redirect ? target : pc;
    end else if (ack) begin
      ir    <= mem.mem_rdata;
      ir_pc <= mem.mem_addr;
      pc    <= pc_add(mem.mem_addr, PC_W'(1));
    end
  end

  fetch_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (issue),
    .enable  ((state == FETCH) && !mem.mem_ack),
    .limit   (LIMIT),
    .expired (expired)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an expected-result scoreboard queue.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] imm_ext = 16'h0000;
  logic [15:0] ir, ir_pc, pc;
  logic        ir_valid, fault;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(16'h0000), .TIMEOUT(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem      (bus.master),
    .fetch_en (fetch_en),
    .redirect (redirect),
    .imm_ext  (imm_ext),
    .ir       (ir),
    .ir_valid (ir_valid),
    .ir_pc    (ir_pc),
    .pc       (pc),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One fetch: push expectation, check the request phase, ack in FETCH cycle d+1, pop and compare.
  task automatic do_fetch(input logic rd, input logic [15:0] imm, input int d,
                          input logic [15:0] rdata, input logic [15:0] addr);
    exp_t e;
    @(negedge clk);
    fetch_en = 1'b1; redirect = rd; imm_ext = imm;
    e.ir = rdata; e.ir_pc = addr; e.pc = addr + 16'd1;
    sb.push_back(e);
    @(negedge clk);
    fetch_en = 1'b0; redirect = 1'b0; imm_ext = 16'h0000;
    chk("mem_req_on", {15'd0, bus.mem_req}, 16'd1);
    chk("mem_addr", bus.mem_addr, addr);
    chk("ir_valid_clr", {15'd0, ir_valid}, 16'd0);
    repeat (d) @(negedge clk);
    chk("mem_addr_hold", bus.mem_addr, addr);
    chk("no_fault_wait", {15'd0, fault}, 16'd0);
    bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
    @(negedge clk);
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'hDEAD;
    chk("ir_valid_set", {15'd0, ir_valid}, 16'd1);
    chk("mem_req_off", {15'd0, bus.mem_req}, 16'd0);
    chk("fault_after_ack", {15'd0, fault}, 16'd0);
    if (sb.size() == 0) begin
      chk("sb_underflow", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      chk("ir", ir, e.ir);
      chk("ir_pc", ir_pc, e.ir_pc);
      chk("pc", pc, e.pc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 16'h0000;

    // Reset values
    @(negedge clk);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_ir_pc", ir_pc, 16'h0000);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_mem_req", {15'd0, bus.mem_req}, 16'd0);
    chk("rst_ir_valid", {15'd0, ir_valid}, 16'd0);
    chk("rst_fault", {15'd0, fault}, 16'd0);
    rst_n = 1'b1;

    // Plain fetch, ack in third FETCH cycle
    do_fetch(1'b0, 16'h0000, 2, 16'h4105, 16'h0000);
    // Redirect from ir_pc=0 to 0x0010
    do_fetch(1'b1, 16'h0010, 0, 16'h1234, 16'h0010);
    // Negative offset: 0x0010 + 0xFFFC = 0x000C
    do_fetch(1'b1, 16'hFFFC, 1, 16'h2222, 16'h000C);
    // 0x000C + 0xFFF3 = 0xFFFF, then pc wraps to 0
    do_fetch(1'b1, 16'hFFF3, 0, 16'hBEEF, 16'hFFFF);

    // Stray ack in VALID changes nothing
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h7777;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("stray_ir", ir, 16'hBEEF);
    chk("stray_ir_pc", ir_pc, 16'hFFFF);
    chk("stray_valid", {15'd0, ir_valid}, 16'd1);
    chk("stray_req", {15'd0, bus.mem_req}, 16'd0);

    // Ack on the 16th FETCH cycle: no fault
    do_fetch(1'b0, 16'h0000, 15, 16'h5A5A, 16'h0000);

    // Reset mid-FETCH, then a late ack
    @(negedge clk);
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    chk("rf_req_before", {15'd0, bus.mem_req}, 16'd1);
    #1 rst_n = 1'b0;
    #1 chk("rf_req_async", {15'd0, bus.mem_req}, 16'd0);
    chk("rf_pc_async", pc, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h5555;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("rf_ir_valid", {15'd0, ir_valid}, 16'd0);
    chk("rf_ir", ir, 16'h0000);
    chk("rf_ir_pc", ir_pc, 16'h0000);
    chk("rf_mem_addr", bus.mem_addr, 16'h0000);
    chk("rf_req", {15'd0, bus.mem_req}, 16'd0);

    // Timeout: no ack for 16 FETCH cycles
    @(negedge clk);
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    repeat (15) @(negedge clk);
    chk("to_req_cycle16", {15'd0, bus.mem_req}, 16'd1);
    chk("to_nofault_cycle16", {15'd0, fault}, 16'd0);
    @(negedge clk);
    chk("to_fault", {15'd0, fault}, 16'd1);
    chk("to_req_off", {15'd0, bus.mem_req}, 16'd0);
    chk("to_ir_valid", {15'd0, ir_valid}, 16'd0);
    fetch_en = 1'b1; redirect = 1'b1; imm_ext = 16'h0005;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h9999;
    repeat (3) @(negedge clk);
    fetch_en = 1'b0; redirect = 1'b0; bus.mem_ack = 1'b0;
    chk("flt_sticky", {15'd0, fault}, 16'd1);
    chk("flt_req", {15'd0, bus.mem_req}, 16'd0);
    chk("flt_ir_valid", {15'd0, ir_valid}, 16'd0);
    chk("flt_pc", pc, 16'h0000);
    chk("flt_ir", ir, 16'h0000);

    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
